// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter that time-shares one external adder among N_REQ requesters.
//
// One operation at a time: a requester is granted in IDLE, its operands are driven to the shared
// adder for LAT cycles (EXEC), and the captured sum is then presented as a response until it is
// accepted (RESP).
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_a/b    packed operands, slice i belongs to requester i
//   req_ready  one-hot accept, combinational, only in IDLE
//   add_a/b    operands to the shared adder (held between operations)
//   add_sum    adder result, valid LAT cycles after add_a/add_b change
//   rsp_valid  response valid (state RESP)
//   rsp_sum    captured W+1 bit sum
//   rsp_id     index of the requester owning the response
//   rsp_ready  response consumer ready
//   busy       high whenever the FSM is not IDLE
module add_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  input  logic [W:0]               add_sum,
  output logic                     rsp_valid,
  output logic [W:0]               rsp_sum,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  // Enough for LAT up to 3 (counts 0..LAT-1).
  localparam int unsigned CntW = 2;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  logic [IdxW-1:0] id_q, id_d;
  logic [W:0]      sum_q, sum_d;

  // Round-robin pick: first valid requester found scanning ptr, ptr+1, ... modulo N_REQ.
  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept is combinational; gated by rst so it drops the instant reset asserts.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && gnt_found) begin
      req_ready = N_REQ'(1) << gnt_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    id_d    = id_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          state_d = StExec;
          ptr_d   = IdxW'((32'(gnt_idx) + 1) % N_REQ);
          cnt_d   = '0;
          add_a_d = req_a[gnt_idx*W +: W];
          add_b_d = req_b[gnt_idx*W +: W];
          id_d    = gnt_idx;
        end
      end
      StExec: begin
        // Final EXEC cycle: adder output has settled for the registered operands.
        if (cnt_q == CntW'(LAT - 1)) begin
          sum_d   = add_sum;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule
